// File: rtl/muldiv_unit_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide unit.
// master: drives start/op/a/b/cancel, observes busy/done/hi/lo/div_zero.
// slave : the muldiv unit itself.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a 2*WIDTH {hi,lo} result for HILO.
// Latency: MUL done at N+MUL_STAGES+1, DIV done at N+WIDTH+2 (N = accepting cycle).
// Backpressure: busy (combinational) stalls the pipe; start is ignored while an op runs.
// Ports: clk_i, rst_ni (async active-low), bus (muldiv_unit_if.slave: start/op/a/b/cancel in,
//        busy/done/hi/lo/div_zero out).
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = (($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             op_u_q;
  logic             neg_quo_q, neg_rem_q, bzero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_q;

  logic             idle_or_done;
  logic             a_neg_d, b_neg_d;
  logic [WIDTH-1:0] a_mag_d, b_mag_d;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);

  assign bus.busy = (bus.start & idle_or_done) |
                    (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

  // Operand signs only matter for the signed ops (op[0]==0).
  assign a_neg_d = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg_d = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_mag_d = a_neg_d ? (~bus.a + 1'b1) : bus.a;
  assign b_mag_d = b_neg_d ? (~bus.b + 1'b1) : bus.b;

  // Extending to 2W and keeping the low 2W bits of the product gives the correct
  // two's-complement result for signed ops and the plain product for unsigned ones.
  assign a_ext = op_u_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = op_u_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign trial_ok = ~trial[WIDTH];
  assign rem_d    = trial_ok ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_d    = {quo_q[WIDTH-2:0], trial_ok};

  // MIN / -1 falls out naturally: |MIN| is MIN as unsigned and its negation wraps to MIN.
  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_u_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.cancel) begin
        // Flush: drop the op in flight, results keep their last written values.
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              a_q       <= bus.a;
              b_q       <= bus.b;
              op_u_q    <= bus.op[0];
              neg_quo_q <= a_neg_d ^ b_neg_d;
              neg_rem_q <= a_neg_d;
              bzero_q   <= (bus.b == '0);
              rem_q     <= '0;
              quo_q     <= a_mag_d;
              dvs_q     <= b_mag_d;
              cnt_q     <= '0;
              dz_q      <= 1'b0;
              state_q   <= bus.op[1] ? S_DIV : S_MUL;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_MUL: begin
            if (cnt_q == MUL_LAST) begin
              hi_q    <= prod[2*WIDTH-1:WIDTH];
              lo_q    <= prod[WIDTH-1:0];
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == DIV_LAST) begin
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_FIX: begin
            // Divide by zero still ran all iterations; override with the defined result.
            if (bzero_q) begin
              lo_q <= '1;
              hi_q <= a_q;
              dz_q <= 1'b1;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, MUL_STAGES=2): directed vectors push the
// expected {hi,lo,div_zero,done cycle}; a monitor pops and compares on every done pulse.
// Also covers busy timing, cancel, async reset mid-op and back-to-back starts.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 34;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_hi", 64'(bus.hi), 64'(e.hi));
        check("result_lo", 64'(bus.lo), 64'(e.lo));
        check("result_div_zero", 64'(bus.div_zero), 64'(e.dz));
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic push_exp(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                          input int due);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.due = due;
    sb_q.push_back(e);
  endtask

  // Issues one op, checks busy through the op and low in the done cycle.
  // Operands are scrambled after acceptance to prove they were latched.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int lat);
    int n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    n = cyc;
    push_exp(ehi, elo, edz, n + lat);
    @(negedge clk);
    check("busy_accept", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) check("busy_inflight", 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    check("busy_done_cycle", 64'(bus.busy), 64'd0);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    #12;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    #5 rst_n = 1'b1;

    // Multiplies
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, LAT_MUL);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, LAT_MUL);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0, LAT_MUL);
    // Divides
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT_DIV);
    run_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, LAT_DIV);
    run_op(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_DIV);
    // Divide by zero, then a multiply clears div_zero
    run_op(OP_DIVU,  32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, LAT_DIV);
    run_op(OP_MULTU, 32'd9, 32'd4, 32'd0, 32'd36, 1'b0, LAT_MUL);
    run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, LAT_DIV);
    // MIN / -1
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, LAT_DIV);
    // Leave a non-zero held result for the cancel/reset checks
    run_op(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_DIV);

    // Cancel at N+10 with start also high: cancel wins, no done, results held
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
    n = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("cancel_cycle_index", 64'(cyc), 64'(n + 10));
    bus.cancel = 1'b1; bus.start = 1'b1; bus.op = OP_MULTU;
    @(posedge clk); #1;
    bus.cancel = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("cancel_busy_low", 64'(bus.busy), 64'd0);
    check("cancel_hold_hi", 64'(bus.hi), 64'd2);
    check("cancel_hold_lo", 64'(bus.lo), 64'd14);
    repeat (40) @(negedge clk);
    check("cancel_hold_lo_late", 64'(bus.lo), 64'd14);

    // Async reset in the middle of a divide
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    #3 rst_n = 1'b1;
    run_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, LAT_MUL);

    // Back-to-back: new MULT accepted in the done cycle of the previous one
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd7; bus.b = 32'hFFFF_FFFE;
    n = cyc;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, n + 3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFF_FFFD; bus.b = 32'hFFFF_FFFB;
    push_exp(32'd0, 32'd15, 1'b0, n + 6);
    @(negedge clk);
    check("b2b_busy_in_done", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
